// File: rtl/mfp_spi_slave.sv
// SPI mode-0 responder: oversamples SCLK/SS/MOSI in the clk domain and moves bytes through valid/ready ports.
// Defining MFP_SPI_SLAVE_RX_FIFO_EN replaces the RX holding register with a 4-entry FIFO.
module mfp_spi_slave #(
    parameter logic [7:0] TX_IDLE_BYTE = 8'hFF,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_sclk,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       tx_underrun,
    output logic       busy
);

    // Handshakes: a byte moves on any clk edge where valid && ready are both high.
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_d, ss_d;
    logic       sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [2:0] bitcnt;
    logic [6:0] shift_rx;
    logic [7:0] shift_tx;
    logic [7:0] tx_buf;
    logic       tx_full;
    logic [7:0] new_byte;

    logic       entry, leave, in_shift, bit_rise, bit_fall;
    logic       reload, byte_done, tx_wr, ovr_set;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Strobes are registered, giving SYNC_STAGES+2 clks from SCLK pin edge to rx_valid.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            ss_rise   <= ss_s & ~ss_d;
            ss_fall   <= ~ss_s & ss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        spi_miso = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) state_d = SHIFT;
            end
            SHIFT: begin
                busy     = 1'b1;
                spi_miso = shift_tx[7];
                if (ss_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign entry     = (state_q == IDLE) && ss_fall;
    assign leave     = (state_q == SHIFT) && ss_rise;
    assign in_shift  = (state_q == SHIFT) && !ss_rise;
    assign bit_rise  = in_shift && sclk_rise;
    assign bit_fall  = in_shift && sclk_fall;
    assign reload    = entry || (bit_fall && (bitcnt == 3'd0));
    assign byte_done = bit_rise && (bitcnt == 3'd7);
    assign tx_wr     = tx_valid && !tx_full;
    assign tx_ready  = !tx_full;
    assign new_byte  = {shift_rx, mosi_s};

    // A reload drains the buffer; a write in the same cycle still lands afterwards.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bitcnt      <= 3'd0;
            shift_rx    <= 7'd0;
            shift_tx    <= 8'd0;
            tx_buf      <= 8'd0;
            tx_full     <= 1'b0;
            tx_underrun <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            tx_underrun <= reload && !tx_full;
            if (tx_wr) tx_buf <= tx_data;
            if (reload)     tx_full <= tx_wr;
            else if (tx_wr) tx_full <= 1'b1;

            if (entry || leave) begin
                bitcnt   <= 3'd0;
                shift_rx <= 7'd0;
            end else if (bit_rise) begin
                shift_rx <= {shift_rx[5:0], mosi_s};
                bitcnt   <= bitcnt + 3'd1;
            end

            if (reload)        shift_tx <= tx_full ? tx_buf : TX_IDLE_BYTE;
            else if (bit_fall) shift_tx <= {shift_tx[6:0], 1'b0};

            if (ovr_set)          overrun <= 1'b1;
            else if (overrun_clr) overrun <= 1'b0;
        end
    end

`ifdef MFP_SPI_SLAVE_RX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       pop, push, fifo_full;

    assign fifo_full = (count == 3'd4);
    assign pop       = rx_ready && (count != 3'd0);
    assign push      = byte_done && (!fifo_full || pop);
    assign ovr_set   = byte_done && fifo_full && !pop;
    assign rx_valid  = (count != 3'd0);
    assign rx_data   = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= new_byte;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end
`else
    assign ovr_set = byte_done && rx_valid && !rx_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
        end else if (byte_done && !(rx_valid && !rx_ready)) begin
            rx_data  <= new_byte;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mfp_spi_slave.sv
// Directed bench for mfp_spi_slave: acts as a mode-0 SPI master at SCLK = clk/16.
module tb_mfp_spi_slave;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_ss = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overrun;
    logic       overrun_clr = 1'b0;
    logic       tx_underrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int underrun_cnt = 0;
    int rx_rise_cnt = 0;
    logic rx_valid_prev = 1'b0;

`ifdef MFP_SPI_SLAVE_RX_FIFO_EN
    localparam logic EXP_OVR = 1'b0;
`else
    localparam logic EXP_OVR = 1'b1;
`endif

    mfp_spi_slave #(.TX_IDLE_BYTE(8'hFF), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_ss(spi_ss),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
        .overrun_clr(overrun_clr), .tx_underrun(tx_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_underrun) underrun_cnt++;
        if (rx_valid && !rx_valid_prev) rx_rise_cnt++;
        rx_valid_prev = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Shifts out the top nbits of mosi_b; MISO is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] mosi_b, input int nbits, input bit lat_chk,
                            output logic [7:0] miso_b);
        miso_b = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = mosi_b[i];
            tick(HALF);
            miso_b[i] = spi_miso;
            spi_sclk = 1'b1;
            if (lat_chk && i == 0) begin
                tick(SYNC + 1);
                check("rx_lat_early", rx_valid, 0);
                tick(1);
                check("rx_lat", rx_valid, 1);
                tick(HALF - SYNC - 2);
            end else begin
                tick(HALF);
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic drain_rx();
        rx_ready = 1'b1;
        for (int k = 0; k < 8 && rx_valid; k++) tick(1);
        rx_ready = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [7:0] m1, m2;
        int base_u, base_r;

        tick(3);
        check("rst_miso", spi_miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        resetn = 1'b1;
        tick(2);

        // SCLK toggling with SS high is ignored
        for (int i = 0; i < 6; i++) begin
            spi_sclk = ~spi_sclk;
            spi_mosi = ~spi_mosi;
            tick(HALF);
        end
        spi_sclk = 1'b0;
        tick(4);
        check("idle_miso", spi_miso, 0);
        check("idle_busy", busy, 0);
        check("idle_rx_valid", rx_valid, 0);
        check("idle_underrun", underrun_cnt, 0);

        // Single byte: send A5 while receiving 3C
        write_tx(8'hA5);
        check("tx_ready_full", tx_ready, 0);
        spi_ss = 1'b0;
        tick(HALF);
        check("busy_on", busy, 1);
        check("tx_ready_loaded", tx_ready, 1);
        spi_bits(8'h3C, 8, 1'b1, m1);
        check("miso_a5", m1, 8'hA5);
        check("rx_3c", rx_data, 8'h3C);
        spi_ss = 1'b1;
        tick(HALF);
        check("busy_off", busy, 0);
        check("no_underrun_1", underrun_cnt, 0);
        drain_rx();
        check("rx_consumed", rx_valid, 0);

        // Two bytes, TX buffer empty for byte 2
        rx_ready = 1'b1;
        write_tx(8'h42);
        base_u = underrun_cnt;
        spi_ss = 1'b0;
        tick(HALF);
        spi_bits(8'h01, 8, 1'b0, m1);
        tick(6);
        check("underrun_b1", underrun_cnt - base_u, 1);
        spi_bits(8'h02, 8, 1'b0, m2);
        tick(6);
        spi_ss = 1'b1;
        tick(HALF);
        check("miso_b1", m1, 8'h42);
        check("miso_b2_idle", m2, 8'hFF);
        check("underrun_b2", underrun_cnt - base_u, 2);
        check("rx_b2", rx_data, 8'h02);
        check("rx_b2_taken", rx_valid, 0);
        check("no_ovr", overrun, 0);
        rx_ready = 1'b0;

        // Two bytes without consumer
        spi_ss = 1'b0;
        tick(HALF);
        spi_bits(8'h11, 8, 1'b0, m1);
        spi_bits(8'h22, 8, 1'b0, m1);
        tick(6);
        spi_ss = 1'b1;
        tick(HALF);
        check("ovr_rx_data", rx_data, 8'h11);
        check("ovr_rx_valid", rx_valid, 1);
        check("ovr_set", overrun, EXP_OVR);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);
        drain_rx();
        check("ovr_drained", rx_valid, 0);

        // SS dropped after 5 bits, then a full byte
        base_r = rx_rise_cnt;
        spi_ss = 1'b0;
        tick(HALF);
        spi_bits(8'hF0, 5, 1'b0, m1);
        spi_ss = 1'b1;
        tick(HALF);
        check("abort_no_rx", rx_valid, 0);
        spi_ss = 1'b0;
        tick(HALF);
        spi_bits(8'h81, 8, 1'b0, m1);
        tick(6);
        spi_ss = 1'b1;
        tick(HALF);
        check("abort_rx_81", rx_data, 8'h81);
        check("abort_one_rx", rx_rise_cnt - base_r, 1);
        drain_rx();

        // Reset mid-byte, then a clean transfer
        write_tx(8'h77);
        spi_ss = 1'b0;
        tick(HALF);
        spi_bits(8'hC3, 3, 1'b0, m1);
        resetn = 1'b0;
        tick(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        spi_ss = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(4);
        spi_ss = 1'b0;
        tick(HALF);
        spi_bits(8'h5A, 8, 1'b0, m1);
        tick(6);
        spi_ss = 1'b1;
        tick(HALF);
        check("post_rst_rx", rx_data, 8'h5A);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_miso_idle", m1, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
